// File: rtl/max_tracker_pkg.sv
// ============================================================================
// Module : max_tracker_pkg
// Brief  : Shared state codes, sample type and index-width helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package max_tracker_pkg;

  typedef logic [3:0] sample_t;

  localparam logic ST_ACCUM = 1'b0;
  localparam logic ST_HOLD  = 1'b1;

  // A one-sample window still needs a 1-bit index and counter.
  function automatic int idx_width(input int window);
    return (window > 1) ? $clog2(window) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/max_tracker_gt4.sv
// ============================================================================
// Module : gt4
// Brief  : Gate-level unsigned 4-bit comparator, o_gt = (i_a > i_b).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gt4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic       o_gt
);

  logic [3:0] w_gt;
  logic [3:1] w_eq;

  assign w_gt = i_a & ~i_b;
  assign w_eq = ~(i_a[3:1] ^ i_b[3:1]);

  // Ripple from the MSB: a lower bit decides only while all higher bits match.
  assign o_gt = w_gt[3]
              | (w_eq[3] & w_gt[2])
              | (w_eq[3] & w_eq[2] & w_gt[1])
              | (w_eq[3] & w_eq[2] & w_eq[1] & w_gt[0]);

endmodule

`default_nettype wire

// File: rtl/max_tracker.sv
// ============================================================================
// Module : max_tracker
// Brief  : Windowed running maximum (and optional minimum) of 4-bit samples,
//          result presented over valid/ready. Define MAX_TRACKER_MIN_EN to add
//          the out_min / out_min_idx ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module max_tracker
  import max_tracker_pkg::*;
#(
  parameter  int WINDOW = 8,
  localparam int IDX_W  = idx_width(WINDOW)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_max,
  output logic [IDX_W-1:0] out_idx
`ifdef MAX_TRACKER_MIN_EN
  ,
  output logic [3:0]       out_min,
  output logic [IDX_W-1:0] out_min_idx
`endif
);

  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(WINDOW - 1);

  logic             r_state;
  logic             w_state_nxt;
  logic [IDX_W-1:0] r_count;
  sample_t          r_max;
  logic [IDX_W-1:0] r_idx;
  logic             w_accept;
  logic             w_first;
  logic             w_last;
  logic             w_gt_max;

  assign w_accept = in_valid & in_ready;
  assign w_first  = (r_count == '0);
  assign w_last   = (r_count == c_LAST);

  gt4 u_gt_max (
    .i_a  (in_data),
    .i_b  (r_max),
    .o_gt (w_gt_max)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_ACCUM;
    end else begin
      case (r_state)
        ST_ACCUM: if (w_accept && w_last) w_state_nxt = ST_HOLD;
        ST_HOLD:  if (out_ready)          w_state_nxt = ST_ACCUM;
        default:                          w_state_nxt = ST_ACCUM;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state == ST_ACCUM);
    out_valid = (r_state == ST_HOLD);
  end

  // Result registers double as the running max; they only move on an accept,
  // so they are naturally frozen in HOLD and across a clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
      r_max   <= '0;
      r_idx   <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= w_last ? '0 : r_count + IDX_W'(1);
      if (w_first || w_gt_max) begin
        r_max <= in_data;
        r_idx <= r_count;
      end
    end
  end

  assign out_max = r_max;
  assign out_idx = r_idx;

`ifdef MAX_TRACKER_MIN_EN
  sample_t          r_min;
  logic [IDX_W-1:0] r_min_idx;
  logic             w_lt_min;

  gt4 u_gt_min (
    .i_a  (r_min),
    .i_b  (in_data),
    .o_gt (w_lt_min)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_min     <= '0;
      r_min_idx <= '0;
    end else if (!clear && w_accept && (w_first || w_lt_min)) begin
      r_min     <= in_data;
      r_min_idx <= r_count;
    end
  end

  assign out_min     = r_min;
  assign out_min_idx = r_min_idx;
`endif

endmodule

`default_nettype wire

// File: tb/tb_max_tracker.sv
// ============================================================================
// Module : tb_max_tracker
// Brief  : Self-checking bench for max_tracker against a window-scan model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_max_tracker;

  localparam int WINDOW = 8;
  localparam int IDX_W  = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_max;
  logic [IDX_W-1:0] out_idx;
`ifdef MAX_TRACKER_MIN_EN
  logic [3:0]       out_min;
  logic [IDX_W-1:0] out_min_idx;
`endif

  always #5 clk = ~clk;

  max_tracker #(.WINDOW(WINDOW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx)
`ifdef MAX_TRACKER_MIN_EN
    ,
    .out_min     (out_min),
    .out_min_idx (out_min_idx)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model: buffered window samples, hold flag and the scanned result.
  logic [3:0] m_win[$];
  logic       m_hold;
  logic       m_fresh;
  int         m_max, m_idx, m_min, m_min_idx;
  int         windows_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_win.delete();
    m_hold = 1'b0; m_fresh = 1'b1;
    m_max = 0; m_idx = 0; m_min = 0; m_min_idx = 0;
  endtask

  task automatic model_close_window();
    m_max = m_win[0]; m_idx = 0; m_min = m_win[0]; m_min_idx = 0;
    for (int i = 1; i < m_win.size(); i++) begin
      if (int'(m_win[i]) > m_max) begin m_max = m_win[i]; m_idx = i; end
      if (int'(m_win[i]) < m_min) begin m_min = m_win[i]; m_min_idx = i; end
    end
    m_win.delete();
    m_hold = 1'b1;
  endtask

  // One clock: compare outputs on the falling edge, drive, then advance model.
  task automatic step(input logic rn, input logic clr, input logic iv,
                      input logic [3:0] d, input logic ordy);
    @(negedge clk);
    chk("in_ready", in_ready, !m_hold);
    chk("out_valid", out_valid, m_hold);
    if (m_hold || m_fresh) begin
      chk("out_max", out_max, m_max);
      chk("out_idx", out_idx, m_idx);
`ifdef MAX_TRACKER_MIN_EN
      chk("out_min", out_min, m_min);
      chk("out_min_idx", out_min_idx, m_min_idx);
`endif
    end
    reset_n = rn; clear = clr; in_valid = iv; out_ready = ordy;
    in_data = iv ? d : 4'bxxxx;
    @(posedge clk);
    if (!rn) model_reset();
    else if (clr) begin m_win.delete(); m_hold = 1'b0; end
    else if (m_hold) begin
      if (ordy) begin m_hold = 1'b0; windows_done++; end
    end else if (iv) begin
      m_fresh = 1'b0;
      m_win.push_back(d);
      if (m_win.size() == WINDOW) model_close_window();
    end
  endtask

  task automatic feed(input logic [31:0] packed_s);
    for (int i = 0; i < WINDOW; i++) step(1'b1, 1'b0, 1'b1, packed_s[4*i +: 4], 1'b0);
  endtask

  task automatic expect_result(input string name, input int mx, input int ix);
    #1;
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_max"}, out_max, mx);
    chk({name, "_idx"}, out_idx, ix);
  endtask

  initial begin
    logic [31:0] s;
    int cyc;
    windows_done = 0;
    model_reset();
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_max", out_max, 0);

    // samples listed LSB-nibble first: 3,9,2,9,5,0,1,7
    s = 32'h7105_9293; feed(s); expect_result("win_basic", 9, 1);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    #1; chk("release_in_ready", in_ready, 1'b1);

    s = 32'h6666_6666; feed(s); expect_result("win_equal", 6, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, i[0], 4'hF, 1'b0);
    expect_result("win_backpressure", 6, 0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);

    s = 32'h0000_0000; feed(s); expect_result("win_zero", 0, 0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    s = 32'hF765_4321; feed(s); expect_result("win_last15", 15, 7);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 4'(10 + i), 1'b0);
    step(1'b1, 1'b1, 1'b1, 4'd14, 1'b0);
    s = 32'h2222_2222; feed(s); expect_result("win_after_clear", 2, 0);

    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    chk("hold_reset_out_valid", out_valid, 1'b0);
    chk("hold_reset_out_max", out_max, 0);
    chk("hold_reset_out_idx", out_idx, 0);
    chk("hold_reset_in_ready", in_ready, 1'b1);

`ifdef MAX_TRACKER_MIN_EN
    s = 32'h5283_1814; feed(s); expect_result("win_minmax", 8, 2);
    chk("win_minmax_min", out_min, 1);
    chk("win_minmax_min_idx", out_min_idx, 1);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
`endif

    windows_done = 0;
    cyc = 0;
    while (windows_done < 1000 && cyc < 60000) begin
      step(($urandom_range(0, 799) != 0),
           ($urandom_range(0, 299) == 0),
           ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) != 0));
      cyc++;
    end
    chk("random_windows_done", (windows_done >= 1000), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
